instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the control unit (`cu`). It holds a loadable 32×17-bit program memory and a program counter, and issues instructions to `cu` over a valid/ready handshake. It also resolves the conditional-branch opcode locally against the flag vector that `cu` returns, and stops after the configured end address. It replaces free-running delay-counter sequencing with explicit handshakes.

## Interface
- `ADDR_W`, 5, PC / memory address width; depth = 2**ADDR_W
- `INSTR_W`, 17, instruction width
- `FLAG_W`, 5, width of flag vector from `cu`
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `load_en` input 1 — program memory write strobe
- `load_addr` input ADDR_W — write address
- `load_data` input INSTR_W — write data
- `start` input 1 — one-cycle pulse, begin execution at PC 0
- `end_addr` input ADDR_W — address of last instruction; sampled on accepted `start`
- `instr_out` output INSTR_W — instruction to `cu`
- `instr_valid` output 1 — `instr_out` valid
- `instr_ready` input 1 — `cu` accepts instruction
- `flags` input FLAG_W — flag vector from `cu`
- `flags_valid` input 1 — `cu` has retired all issued instructions; `flags` stable
- `pc_out` output ADDR_W — current PC
- `busy` output 1 — state is not IDLE/HALT
- `halted` output 1 — program finished

## Operation
- Instruction fields: [16:12] opcode, [11:9] flag select, [8:4] branch target. Branch opcode is 5'b11111.
- States: IDLE, FETCH, ISSUE, BRANCH, HALT.
- IDLE/HALT + `start`: PC←0, latch `end_addr`, clear `halted`, go to FETCH. `start` while busy is ignored.
- FETCH (1 cycle): `instr_out`←mem[PC]. Branch opcode → BRANCH; otherwise `instr_valid`←1 and go to ISSUE.
- ISSUE: hold `instr_out`/`instr_valid` stable until `instr_valid && instr_ready`. On handshake: `instr_valid`←0. If PC==end_addr → HALT; else PC←PC+1 and go to FETCH.
- BRANCH: branch is not sent to `cu`. Wait for `flags_valid`, then:
  - If sel<FLAG_W and flags[sel]==0 → taken, PC←target, FETCH. A taken branch continues even at end_addr.
  - Otherwise → not taken. If PC==end_addr → HALT; else PC←PC+1, FETCH.
- PC increment wraps modulo 2**ADDR_W (31+1→0).
- `load_en` writes memory only in IDLE/HALT; writes while busy are dropped.
- `load_en` and `start` in the same cycle: the write is performed and visible to the first FETCH.
- Memory contents are not reset and are preserved across `rst_n`.

## Timing
- Reset values: `instr_out`=0, `instr_valid`=0, `pc_out`=0, `busy`=0, `halted`=0, state IDLE, latched end_addr=0.
- Reset mid-operation aborts immediately; any pending instruction is dropped (`instr_valid` falls asynchronously).
- `start` at cycle N → FETCH at N+1 → `instr_valid`=1 at N+2.
- Best-case throughput: one non-branch instruction per 2 cycles (FETCH + ISSUE with `instr_ready` high).
- Branch costs 1 cycle plus wait; with `flags_valid` high on BRANCH entry, the next FETCH occurs the following cycle.
- `halted` rises the cycle after the final handshake/resolution and holds until `start` or reset.

## Configuration
- `IFETCH_BRANCH_EN` defined: branch handling as above.
- Not defined: opcode 5'b11111 is issued to `cu` like any other instruction, BRANCH state is removed, and `flags`/`flags_valid` are ignored.

## Structure
- `ifetch_pkg`: state enum; `OP_BRANCH`=5'b11111; field position constants (OPC_HI/LO, SEL_HI/LO, TGT_HI/LO).
- One sub-module, `prog_mem`: 2**ADDR_W × INSTR_W register file with one synchronous write port and one combinational read port.

## Test plan
- Load 3 non-branch words at 0..2, end_addr=2, `instr_ready` tied 1, pulse `start` → three handshakes of the exact words on alternating cycles, then `halted`=1, `pc_out`=2.
- Backpressure: hold `instr_ready`=0 for 5 cycles in ISSUE → `instr_out` stable and `instr_valid`=1 throughout; one handshake only.
- Branch word 17'b11111_000_00001_0000 at address 3, flags=5'b00000, `flags_valid` delayed 4 cycles → no issue during the wait, PC←1; with flags=5'b00001 → PC←4.
- Flag select 6 → not taken; branch at end_addr not taken → HALT.
- `load_en` while busy → memory unchanged (read back after HALT); `start` while busy → ignored.
- Assert `rst_n` low in ISSUE → all outputs at reset values immediately; memory retained; re-`start` reruns the program identically.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
//   state_e   : fetch FSM states (S_BRANCH exists only with IFETCH_BRANCH_EN)
//   OP_BRANCH : conditional-branch opcode
//   *_HI/*_LO : instruction field positions (opcode, flag select, target)
// Optional feature macro: IFETCH_BRANCH_EN
package ifetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
`ifdef IFETCH_BRANCH_EN
        , S_BRANCH
`endif
    } state_e;

    localparam logic [4:0] OP_BRANCH = 5'b11111;

    localparam int OPC_HI = 16;
    localparam int OPC_LO = 12;
    localparam int SEL_HI = 11;
    localparam int SEL_LO = 9;
    localparam int TGT_HI = 8;
    localparam int TGT_LO = 4;

endpackage

// File: rtl/prog_mem.sv
// prog_mem: 2**ADDR_W x INSTR_W program store.
//   clk     : write clock
//   we_i    : write enable (gated by the caller)
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data
// Contents are deliberately not reset so a loaded program survives rst_n.
module prog_mem #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 17
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program memory + PC sequencer feeding the control unit over a
// valid/ready handshake; resolves conditional branches locally.
//   clk, rst_n              : clock, async active-low reset
//   load_en/addr/data       : program write port (honoured only in IDLE/HALT)
//   start, end_addr         : begin at PC 0; end_addr latched on start
//   instr_out/valid/ready   : instruction handshake to cu
//   flags, flags_valid      : cu flag vector, valid once all issued retired
//   pc_out, busy, halted    : status
// Optional feature macro: IFETCH_BRANCH_EN (local branch resolution). When
// undefined, the branch opcode is issued like any other instruction.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 17,
    parameter int FLAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic [ADDR_W-1:0]  end_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic [FLAG_W-1:0]  flags,
    input  logic               flags_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               halted
);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  end_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               halted_q;

    logic               idle_like;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;
    logic [ADDR_W-1:0]  pc_inc;
    logic               at_end;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
    // Writes while a program runs are dropped so the running code is stable.
    assign mem_we    = load_en && idle_like;
    assign pc_inc    = pc_q + 1'b1;  // wraps modulo depth
    assign at_end    = (pc_q == end_q);

    prog_mem #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

`ifdef IFETCH_BRANCH_EN
    logic [SEL_HI-SEL_LO:0] br_sel;
    logic                   br_flag;
    logic                   br_taken;
    logic [ADDR_W-1:0]      br_tgt;
    logic                   fetch_is_br;

    assign fetch_is_br = (mem_rdata[OPC_HI:OPC_LO] == OP_BRANCH);
    assign br_sel      = instr_q[SEL_HI:SEL_LO];
    assign br_tgt      = ADDR_W'(instr_q[TGT_HI:TGT_LO]);

    // Selects beyond the flag vector never take the branch.
    always_comb begin
        br_flag = 1'b1;
        for (int i = 0; i < FLAG_W; i++) begin
            if (int'(br_sel) == i) br_flag = flags[i];
        end
    end

    assign br_taken = (int'(br_sel) < FLAG_W) && !br_flag;
`else
    logic unused_flags;
    assign unused_flags = ^{flags, flags_valid};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            end_q    <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q     <= '0;
                        end_q    <= end_addr;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_q <= mem_rdata;
`ifdef IFETCH_BRANCH_EN
                    if (fetch_is_br) begin
                        state_q <= S_BRANCH;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
`else
                    valid_q <= 1'b1;
                    state_q <= S_ISSUE;
`endif
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (at_end) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            pc_q    <= pc_inc;
                            state_q <= S_FETCH;
                        end
                    end
                end
`ifdef IFETCH_BRANCH_EN
                // Flags are only trusted once cu has drained everything issued.
                S_BRANCH: begin
                    if (flags_valid) begin
                        if (br_taken) begin
                            pc_q    <= br_tgt;
                            state_q <= S_FETCH;
                        end else if (at_end) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            pc_q    <= pc_inc;
                            state_q <= S_FETCH;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign busy        = !idle_like;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

`ifdef IFETCH_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [16:0] load_data;
    logic        start;
    logic [4:0]  end_addr;
    logic [16:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  flags;
    logic        flags_valid;
    logic [4:0]  pc_out;
    logic        busy;
    logic        halted;

    int ntests = 0;
    int nfail  = 0;

    logic [16:0] mem_m [32];
    logic [16:0] exp_q [$];
    logic [4:0]  exp_pc;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .end_addr    (end_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flags       (flags),
        .flags_valid (flags_valid),
        .pc_out      (pc_out),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [16:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        mem_m[a] = d;
    endtask

    // Reference: walk the program as the spec describes it, collecting the
    // words cu should receive and the PC left at halt.
    task automatic model(input logic [4:0] e, input logic [4:0] fl);
        logic [4:0]  pc;
        logic [16:0] w;
        int          sel;
        bit          taken;
        pc = 5'd0;
        exp_q.delete();
        for (int steps = 0; steps < 300; steps++) begin
            w = mem_m[pc];
            taken = 1'b0;
            if (BR_EN && w[16:12] == 5'h1f) begin
                sel = int'(w[11:9]);
                if (sel < 5) taken = (fl[sel] == 1'b0);
                if (taken) pc = w[8:4];
            end else begin
                exp_q.push_back(w);
            end
            if (!taken) begin
                if (pc == e) break;
                pc = pc + 5'd1;
            end
        end
        exp_pc = pc;
    endtask

    task automatic run_prog(input logic [4:0] e, input logic [4:0] fl);
        logic [16:0] ew;
        bit          done;
        model(e, fl);
        @(negedge clk);
        end_addr = e; flags = fl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (halted) begin
                done = 1'b1;
            end else begin
                instr_ready = 1'($urandom % 2);
                flags_valid = (($urandom % 3) == 0);
                if (instr_valid) begin
                    ew = (exp_q.size() > 0) ? exp_q[0] : 17'bx;
                    chk("issue_word", 32'(instr_out), 32'(ew));
                    if (instr_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                @(negedge clk);
            end
        end
        chk("run_halted", 32'(halted), 32'd1);
        chk("run_pc", 32'(pc_out), 32'(exp_pc));
        chk("run_remaining", exp_q.size(), 32'd0);
        instr_ready = 1'b0;
        flags_valid = 1'b0;
    endtask

    initial begin
        logic [16:0] w;
        logic [4:0]  e;
        int          sel;
        int          tgt;

        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; end_addr = '0; instr_ready = 1'b0;
        flags = '0; flags_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Three words, ready high: handshakes on alternating cycles; word 0 is
        // written in the same cycle as start.
        load(5'd1, 17'h0ABCD);
        load(5'd2, 17'h12345);
        @(negedge clk);
        load_en = 1'b1; load_addr = 5'd0; load_data = 17'h05A5A; mem_m[0] = 17'h05A5A;
        start = 1'b1; end_addr = 5'd2; instr_ready = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            chk("seq_valid", 32'(instr_valid), 32'(i % 2));
            if (i % 2 == 1) chk("seq_word", 32'(instr_out), 32'(mem_m[(i - 1) / 2]));
            if (i < 6) @(negedge clk);
        end
        chk("seq_halted", 32'(halted), 32'd1);
        chk("seq_pc", 32'(pc_out), 32'd2);
        chk("seq_busy", 32'(busy), 32'd0);
        instr_ready = 1'b0;

        // Backpressure, plus load and start while busy
        load(5'd0, 17'h01111);
        @(negedge clk);
        end_addr = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_word", 32'(instr_out), 32'h01111);
            chk("bp_pc", 32'(pc_out), 32'd0);
            load_en = (i == 1); load_addr = 5'd0; load_data = 17'h1EEEE;
            start = (i == 2); end_addr = 5'd7;
            @(negedge clk);
        end
        load_en = 1'b0; start = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("bp_after_valid", 32'(instr_valid), 32'd0);
        chk("bp_after_halted", 32'(halted), 32'd1);
        run_prog(5'd0, 5'd0);   // memory still holds the original word

`ifdef IFETCH_BRANCH_EN
        // Branch with delayed flags_valid: taken to 1, later not taken to 4
        load(5'd0, 17'h00A01);
        load(5'd1, 17'h00B02);
        load(5'd2, 17'h00C03);
        load(5'd3, 17'b11111_000_00001_0000);
        load(5'd4, 17'h00D04);
        @(negedge clk);
        end_addr = 5'd4; flags = 5'b00000; flags_valid = 1'b0;
        instr_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("br_wait_valid", 32'(instr_valid), 32'd0);
            chk("br_wait_pc", 32'(pc_out), 32'd3);
            chk("br_wait_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        flags_valid = 1'b1;
        @(negedge clk);
        flags_valid = 1'b0;
        chk("br_taken_pc", 32'(pc_out), 32'd1);
        flags = 5'b00001; flags_valid = 1'b1;
        for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
        chk("br_nt_halted", 32'(halted), 32'd1);
        chk("br_nt_pc", 32'(pc_out), 32'd4);
        instr_ready = 1'b0; flags_valid = 1'b0;
`endif

        // Flag select 6 never taken; branch at end_addr not taken -> halt
        load(5'd0, {5'h1f, 3'd6, 5'd9, 4'd0});
        run_prog(5'd0, 5'd0);
        load(5'd0, 17'h00123);
        load(5'd1, {5'h1f, 3'd2, 5'd0, 4'd0});
        run_prog(5'd1, 5'b00100);

        // Reset while in ISSUE
        load(5'd0, 17'h0F00F);
        load(5'd1, 17'h00F0F);
        load(5'd2, 17'h10101);
        @(negedge clk);
        end_addr = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr_out), 32'd0);
        chk("arst_pc", 32'(pc_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(5'd2, 5'd0);

        // Random programs; forward-only branch targets keep every run finite
        for (int r = 0; r < 25; r++) begin
            e = 5'($urandom_range(0, 31));
            for (int a = 0; a <= int'(e); a++) begin
                if ($urandom % 4 == 0) begin
                    if (a == int'(e)) begin
                        sel = $urandom_range(5, 7);
                        tgt = $urandom_range(0, 31);
                    end else begin
                        sel = $urandom_range(0, 7);
                        tgt = $urandom_range(a + 1, int'(e));
                    end
                    w = {5'h1f, 3'(sel), 5'(tgt), 4'($urandom)};
                end else begin
                    w = 17'($urandom);
                    if (w[16:12] == 5'h1f) w[12] = 1'b0;
                end
                load(5'(a), w);
            end
            run_prog(e, 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
